// File: rtl/adc_sched_pkg.sv
// ============================================================================
//  adc_sched_pkg : shared constants and state encoding for adc_sample_scheduler
//  Revision: 1.0
// ============================================================================
`default_nettype none

package adc_sched_pkg;

  localparam int ADC_W     = 8;
  localparam int AVG_N     = 4;
  localparam int AVG_SHIFT = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SKIP = 2'd1,
    CAP  = 2'd2,
    RESP = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
//  rr_arbiter : combinational round-robin select, search starts at ptr
//  Revision: 1.0
// ============================================================================
`default_nettype none

module rr_arbiter
  import adc_sched_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
  output logic                       valid
);

  localparam int IW = $clog2(NUM_REQ);

  always_comb begin : p_select
    int          j;
    logic [IW-1:0] sel;
    gnt     = '0;
    gnt_idx = '0;
    valid   = 1'b0;
    j       = 0;
    sel     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      sel = j[IW-1:0];
      if (!valid && req[sel]) begin
        valid    = 1'b1;
        gnt[sel] = 1'b1;
        gnt_idx  = sel;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/adc_sample_scheduler.sv
// ============================================================================
//  adc_sample_scheduler : round-robin sharing of one serial ADC driver with
//  stale-conversion flush and per-strobe timeout. ADC_SCHED_AVG_EN enables
//  4-sample averaging.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module adc_sample_scheduler
  import adc_sched_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int SKIP_DONES  = 1,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               rsp_valid,
  output logic [ADC_W-1:0]   rsp_data,
  output logic               rsp_err,
  output logic               busy,
  input  logic               adc_done,
  input  logic [ADC_W-1:0]   adc_data
);

  localparam int            IW       = $clog2(NUM_REQ);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);
  localparam logic [15:0]   TMO_LAST = 16'(TIMEOUT_CYC - 1);

  state_t             state;
  logic [IW-1:0]      ptr;
  logic [1:0]         skip_cnt;
  logic [15:0]        tmo_cnt;
  logic [NUM_REQ-1:0] arb_gnt;
  logic [IW-1:0]      arb_idx;
  logic               arb_valid;
  logic               tmo_hit;

  assign tmo_hit = !adc_done && (tmo_cnt == TMO_LAST);

`ifdef ADC_SCHED_AVG_EN
  localparam logic [AVG_SHIFT-1:0] AVG_LAST = AVG_SHIFT'(AVG_N - 1);
  logic [ADC_W+AVG_SHIFT-1:0] acc;
  logic [ADC_W+AVG_SHIFT-1:0] acc_sum;
  logic [AVG_SHIFT-1:0]       avg_cnt;
  assign acc_sum = acc + {{AVG_SHIFT{1'b0}}, adc_data};
`endif

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req     (req),
    .ptr     (ptr),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .valid   (arb_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      ptr       <= '0;
      skip_cnt  <= '0;
      tmo_cnt   <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
`ifdef ADC_SCHED_AVG_EN
      acc       <= '0;
      avg_cnt   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // A strobe arriving with the grant belongs to a conversion already in flight.
          if (arb_valid) begin
            gnt      <= arb_gnt;
            ptr      <= (arb_idx == LAST_IDX) ? '0 : arb_idx + 1'b1;
            skip_cnt <= 2'(SKIP_DONES);
            tmo_cnt  <= '0;
            busy     <= 1'b1;
            state    <= (SKIP_DONES > 0) ? SKIP : CAP;
`ifdef ADC_SCHED_AVG_EN
            acc      <= '0;
            avg_cnt  <= '0;
`endif
          end
        end
        SKIP, CAP: begin
          if (adc_done) begin
            tmo_cnt <= '0;
            if (state == SKIP) begin
              skip_cnt <= skip_cnt - 1'b1;
              if (skip_cnt == 2'd1) state <= CAP;
            end else begin
`ifdef ADC_SCHED_AVG_EN
              if (avg_cnt == AVG_LAST) begin
                rsp_data  <= acc_sum[ADC_W+AVG_SHIFT-1:AVG_SHIFT];
                rsp_valid <= 1'b1;
                rsp_err   <= 1'b0;
                state     <= RESP;
              end else begin
                acc     <= acc_sum;
                avg_cnt <= avg_cnt + 1'b1;
              end
`else
              rsp_data  <= adc_data;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
              state     <= RESP;
`endif
            end
          end else if (tmo_hit) begin
            rsp_data  <= '0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            state     <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        RESP: begin
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          gnt       <= '0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_adc_sample_scheduler.sv
// ============================================================================
//  tb_adc_sample_scheduler : directed bench for adc_sample_scheduler
//  (ADC_SCHED_AVG_EN selects the averaging scenario set).
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_adc_sample_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0;
  logic [3:0] gnt;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       busy;
  logic       adc_done = 1'b0;
  logic [7:0] adc_data = 8'd0;

  int         n_cmp = 0;
  int         n_err = 0;
  bit         gen_on = 1'b0;
  int         gen_phase = 0;
  logic [7:0] gen_val = 8'd0;
  int         cyc;

  always #5 clk = ~clk;

  adc_sample_scheduler #(
    .NUM_REQ     (4),
    .SKIP_DONES  (1),
    .TIMEOUT_CYC (255)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .adc_done  (adc_done),
    .adc_data  (adc_data)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Free-running driver model: one strobe every 35 cycles, data counts up.
  task automatic step();
    @(posedge clk);
    #1;
    if (gen_on) begin
      gen_phase++;
      if (gen_phase >= 35) begin
        adc_done  = 1'b1;
        adc_data  = gen_val;
        gen_val   = gen_val + 8'd1;
        gen_phase = 0;
      end else begin
        adc_done = 1'b0;
      end
    end
  endtask

  task automatic pulse(input logic [7:0] d);
    adc_done = 1'b1;
    adc_data = d;
    step();
    adc_done = 1'b0;
  endtask

  task automatic wait_rsp(input int max, output int n);
    n = 0;
    while (rsp_valid !== 1'b1 && n < max) begin
      step();
      n++;
    end
    if (rsp_valid !== 1'b1) chk("rsp_wait", rsp_valid, 1);
  endtask

  task automatic do_reset();
    gen_on   = 1'b0;
    adc_done = 1'b0;
    rst      = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic t_timeout();
    gen_on   = 1'b0;
    adc_done = 1'b0;
    req      = 4'b0010;
    step();
    chk("tmo_gnt", gnt, 4'b0010);
    wait_rsp(400, cyc);
    chk("tmo_latency", cyc, 255);
    chk("tmo_err", rsp_err, 1);
    chk("tmo_data", rsp_data, 0);
    req = 4'b0;
    step();
    chk("tmo_busy_after", busy, 0);
    chk("tmo_gnt_after", gnt, 0);
  endtask

  task automatic t_reset_mid();
    req = 4'b0100;
    step();
    chk("rmid_gnt", gnt, 4'b0100);
    pulse(8'd5);
    step();
    rst = 1'b1;
    #1;
    chk("rmid_gnt_async", gnt, 0);
    chk("rmid_busy_async", busy, 0);
    req = 4'b1100;
    step();
    step();
    chk("rmid_no_rsp", rsp_valid, 0);
    rst = 1'b0;
    step();
    chk("rmid_ptr_zero", gnt, 4'b0100);
    req = 4'b0;
  endtask

`ifdef ADC_SCHED_AVG_EN
  task automatic t_average();
    gen_on = 1'b0;
    req    = 4'b0001;
    step();
    chk("avg_gnt", gnt, 4'b0001);
    pulse(8'd99);
    pulse(8'd10);
    pulse(8'd11);
    pulse(8'd12);
    chk("avg_not_yet", rsp_valid, 0);
    pulse(8'd14);
    chk("avg_valid", rsp_valid, 1);
    chk("avg_data", rsp_data, 11);
    chk("avg_err", rsp_err, 0);
    req = 4'b0;
    step();
  endtask
`else
  task automatic t_single();
    gen_on    = 1'b1;
    gen_phase = 0;
    gen_val   = 8'd100;
    req       = 4'b0001;
    step();
    chk("single_gnt", gnt, 4'b0001);
    chk("single_busy", busy, 1);
    chk("single_no_rsp", rsp_valid, 0);
    wait_rsp(200, cyc);
    chk("single_latency", cyc, 70);
    chk("single_data", rsp_data, 101);
    chk("single_err", rsp_err, 0);
    chk("single_gnt_held", gnt, 4'b0001);
    req = 4'b0;
    step();
    chk("single_pulse_len", rsp_valid, 0);
    chk("single_busy_idle", busy, 0);
    chk("single_gnt_idle", gnt, 0);
    gen_on = 1'b0;
    adc_done = 1'b0;
  endtask

  task automatic t_fairness();
    logic [3:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [7:0] exp_d [5] = '{8'd101, 8'd103, 8'd105, 8'd107, 8'd109};
    do_reset();
    gen_on    = 1'b1;
    gen_phase = 0;
    gen_val   = 8'd100;
    req       = 4'b1111;
    step();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("rr_gnt%0d", k), gnt, exp_g[k]);
      wait_rsp(200, cyc);
      chk($sformatf("rr_data%0d", k), rsp_data, exp_d[k]);
      chk($sformatf("rr_gnt_held%0d", k), gnt, exp_g[k]);
      if (k == 4) req = 4'b0;
      step();
      chk($sformatf("rr_idle_gap%0d", k), gnt, 0);
      step();
    end
    gen_on = 1'b0;
    adc_done = 1'b0;
  endtask

  task automatic t_stale();
    req      = 4'b0100;
    adc_done = 1'b1;
    adc_data = 8'd55;
    step();
    adc_done = 1'b0;
    chk("stale_gnt", gnt, 4'b0100);
    repeat (3) step();
    pulse(8'd60);
    chk("stale_skipped", rsp_valid, 0);
    repeat (2) step();
    pulse(8'd70);
    chk("stale_valid", rsp_valid, 1);
    chk("stale_data", rsp_data, 70);
    req = 4'b0;
    pulse(8'd80);
    chk("resp_done_ignored", rsp_valid, 0);
    chk("resp_data_hold", rsp_data, 70);
    chk("stale_busy_idle", busy, 0);
  endtask
`endif

  initial begin
    step();
    step();
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    rst = 1'b0;
    step();
`ifdef ADC_SCHED_AVG_EN
    t_average();
    t_timeout();
    t_reset_mid();
`else
    t_single();
    t_timeout();
    t_fairness();
    t_stale();
    t_reset_mid();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
